mux_demux_route4: RTL and testbench
===================================

Name: mux_demux_route4

Overview:
- Registered 4-channel route-through block. A 4:1 multiplexer selects one input lane by `s`. A 1:4 demultiplexer then drives the selected value back onto the same lane position of `g`; every other lane of `g` is zero.
- Net effect: `g` is a one-lane-at-a-time "pass mask" of `i`.
- Used as a gate-level mux/demux sanity path and as a lane-isolation stage in front of per-channel consumers.

Parameters:
- `W`, default 1: width in bits of each lane. Total data width is 4*W.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: capture enable. When low, registers hold.
- `i`, input, 4*W: four input lanes. Lane k occupies bits [k*W+W-1 : k*W].
- `s`, input, 2: lane select, 0..3.
- `y`, output, W: registered mux output. Holds the value of the selected lane.
- `g`, output, 4*W: registered demux output. Only lane s carries data; other lanes are 0.
- `s_q`, output, 2: registered copy of the select that produced the current `y`/`g`.

Behaviour:
- Reset (`rst_n` = 0, asynchronous, independent of `clk`):
  - `y` = 0, `g` = 0, `s_q` = 0 immediately.
  - Outputs stay 0 while reset is held.
- Combinational stage, internal:
  - `mux_y` = lane s of `i`.
  - `demux_g` lane k = `mux_y` when k == s, else 0.
  - Built as an explicit 4:1 mux followed by a 1:4 demux, not collapsed into a single masking expression.
- Clock edge with `en` = 1 and `rst_n` = 1:
  - `y` <= `mux_y`
  - `g` <= `demux_g`
  - `s_q` <= `s`
- Clock edge with `en` = 0: `y`, `g` and `s_q` hold their previous values.
- Latency: exactly 1 clock from `i`/`s` sampled at an edge to `y`/`g`/`s_q` updated.
- There is no combinational path from the inputs to the outputs.
- Invariants after every enabled edge:
  - `g` has at most one non-zero lane, and that lane is lane `s_q`.
  - Lane `s_q` of `g` equals `y`.
  - OR-reducing `g` across lanes equals `y`.
- `s` is 2 bits, so all values are legal and there is no out-of-range case. X/Z on `s` is not supported; the bench must drive only known values.
- Simultaneous `i` and `s` change: both are sampled on the same edge, so the output reflects the new lane of the new data.
- Reset released mid-stream: outputs remain 0 until the first enabled rising edge after `rst_n` goes high.
- Deassertion of `rst_n` is assumed synchronised externally to `clk`.
- `W` = 1 is the primary configuration. Any `W` >= 1 must work with identical lane semantics.

Test Plan:
- Reset: hold `rst_n` = 0 with `i` = 4'b1111, `s` = 2, `en` = 1 for 3 clocks → `y` = 0, `g` = 4'b0000, `s_q` = 0 throughout. Also assert `rst_n` = 0 between edges → outputs clear without waiting for a clock edge.
- Lane sweep (W=1): `i` = 4'b1010, `en` = 1, step `s` = 0,1,2,3 one per clock → the cycle after each step gives:
  - `g` = 0000, `y` = 0
  - `g` = 0010, `y` = 1
  - `g` = 0000, `y` = 0
  - `g` = 1000, `y` = 1
- Random sweep: 5 random `i` values, each with `s` stepped 0..3 → after each edge `g` == (`i` & (1 << `s_q`)), `y` == `i[s_q]`, and only one lane of `g` is non-zero.
- Enable hold: capture `i` = 4'b0100 with `s` = 2 (`g` = 0100), then drop `en` and change to `i` = 4'b0001, `s` = 0 for 3 clocks → `g` stays 0100, `y` stays 1, `s_q` stays 2. Re-raise `en` → next edge gives `g` = 0001, `y` = 1, `s_q` = 0.
- Simultaneous change: on the same edge switch `i` 4'b1111 → 4'b0110 and `s` 3 → 1 → next output is `g` = 0010, `y` = 1.
- Wide lanes (W=8): `i` = {8'hD4, 8'h00, 8'h5A, 8'hFF} (lane 3 → lane 0), `s` = 1 → `y` = 8'h5A, `g` = 32'h00005A00.

Source files
------------

// File: rtl/mux_demux_route4.sv
// mux_demux_route4: registered 4-lane route-through.
// An explicit 4:1 mux picks lane s of i. An explicit 1:4 demux then puts that
// value back on lane s of g and drives zeros on the other lanes. y, g and s_q
// are all registered, so no input reaches an output in the same cycle.
`timescale 1ns/1ps
module mux_demux_route4 #(
  parameter int W = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [4*W-1:0] i,
  input  logic [1:0]     s,
  output logic [W-1:0]   y,
  output logic [4*W-1:0] g,
  output logic [1:0]     s_q
);

  logic [W-1:0]   mux_y;
  logic [4*W-1:0] demux_g;
  logic [W-1:0]   y_d;
  logic [W-1:0]   y_q;
  logic [4*W-1:0] g_d;
  logic [4*W-1:0] g_q;
  logic [1:0]     s_d;

  // 4:1 mux: select one input lane by s
  always_comb begin
    mux_y = '0;
    case (s)
      2'd0:    mux_y = i[0*W +: W];
      2'd1:    mux_y = i[1*W +: W];
      2'd2:    mux_y = i[2*W +: W];
      2'd3:    mux_y = i[3*W +: W];
      default: mux_y = '0;
    endcase
  end

  // 1:4 demux: drive the mux result onto lane s, zero elsewhere
  always_comb begin
    demux_g = '0;
    case (s)
      2'd0:    demux_g[0*W +: W] = mux_y;
      2'd1:    demux_g[1*W +: W] = mux_y;
      2'd2:    demux_g[2*W +: W] = mux_y;
      2'd3:    demux_g[3*W +: W] = mux_y;
      default: demux_g = '0;
    endcase
  end

  // Next-state: capture the routed value when enabled, otherwise hold
  always_comb begin
    y_d = y_q;
    g_d = g_q;
    s_d = s_q;
    if (en) begin
      y_d = mux_y;
      g_d = demux_g;
      s_d = s;
    end else begin
      y_d = y_q;
      g_d = g_q;
      s_d = s_q;
    end
  end

  // Output registers, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
      g_q <= '0;
      s_q <= 2'd0;
    end else begin
      y_q <= y_d;
      g_q <= g_d;
      s_q <= s_d;
    end
  end

  assign y = y_q;
  assign g = g_q;

endmodule

// File: tb/tb_mux_demux_route4.sv
// Self-checking bench for mux_demux_route4 (W=1 and W=8 instances).
// Expected outputs are pushed to a scoreboard queue when stimulus is driven
// and popped and compared one cycle later, once the registers have updated.
`timescale 1ns/1ps
module tb_mux_demux_route4;

  typedef struct packed {
    logic       y;
    logic [3:0] g;
    logic [1:0] sq;
  } exp1_t;

  typedef struct packed {
    logic [7:0]  y;
    logic [31:0] g;
    logic [1:0]  sq;
  } expw_t;

  logic        clk;
  logic        rst_n;
  logic        en1;
  logic [3:0]  i1;
  logic [1:0]  s1;
  logic        y1;
  logic [3:0]  g1;
  logic [1:0]  sq1;

  logic        enw;
  logic [31:0] iw;
  logic [1:0]  sw;
  logic [7:0]  yw;
  logic [31:0] gw;
  logic [1:0]  sqw;

  int total;
  int bad;

  exp1_t sb1[$];
  expw_t sbw[$];
  exp1_t m1;
  expw_t mw;

  mux_demux_route4 #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .i(i1), .s(s1),
    .y(y1), .g(g1), .s_q(sq1)
  );

  mux_demux_route4 #(.W(8)) dutw (
    .clk(clk), .rst_n(rst_n), .en(enw), .i(iw), .s(sw),
    .y(yw), .g(gw), .s_q(sqw)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one W=1 cycle, push the expected result, wait until just after the edge
  task automatic cycle1(input logic [3:0] iv, input logic [1:0] sv, input logic ev);
    i1 = iv;
    s1 = sv;
    en1 = ev;
    if (ev) begin
      m1.y  = iv[sv];
      m1.g  = iv & (4'b0001 << sv);
      m1.sq = sv;
    end
    sb1.push_back(m1);
    @(posedge clk);
    #1;
  endtask

  // Drive one W=8 cycle, push the expected result, wait until just after the edge
  task automatic cyclew(input logic [31:0] iv, input logic [1:0] sv, input logic ev);
    iw = iv;
    sw = sv;
    enw = ev;
    if (ev) begin
      mw.y  = 8'((iv >> (sv * 8)) & 32'h0000_00FF);
      mw.g  = iv & (32'h0000_00FF << (sv * 8));
      mw.sq = sv;
    end
    sbw.push_back(mw);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp1_t e;
    rst_n = 1'b0;
    i1 = 4'b1111;
    s1 = 2'd2;
    en1 = 1'b1;
    m1 = '0;
    mw = '0;
    sb1.delete();
    sbw.delete();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      total++;
      if ({y1, g1, sq1} !== 7'b0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got y=%b g=%b s_q=%0d want all zero", k, y1, g1, sq1);
      end
    end
    rst_n = 1'b1;
    cycle1(4'b1111, 2'd2, 1'b1);
    e = sb1.pop_front();
    total++;
    if ({y1, g1, sq1} !== e) begin
      bad++;
      $display("FAIL post_reset_load: got y=%b g=%b s_q=%0d want y=%b g=%b s_q=%0d",
               y1, g1, sq1, e.y, e.g, e.sq);
    end
    // Assert reset between edges: outputs must clear without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    m1 = '0;
    total++;
    if ({y1, g1, sq1} !== 7'b0) begin
      bad++;
      $display("FAIL async_reset: got y=%b g=%b s_q=%0d want all zero", y1, g1, sq1);
    end
    @(posedge clk);
    #1;
    // Release with en low: outputs stay zero until an enabled edge
    rst_n = 1'b1;
    cycle1(4'b1111, 2'd3, 1'b0);
    e = sb1.pop_front();
    total++;
    if ({y1, g1, sq1} !== e) begin
      bad++;
      $display("FAIL reset_release_no_en: got y=%b g=%b s_q=%0d want y=%b g=%b s_q=%0d",
               y1, g1, sq1, e.y, e.g, e.sq);
    end
  endtask

  task automatic test_lane_sweep();
    exp1_t e;
    logic [3:0] g_tab [4];
    logic       y_tab [4];
    g_tab = '{4'b0000, 4'b0010, 4'b0000, 4'b1000};
    y_tab = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      cycle1(4'b1010, 2'(k), 1'b1);
      e = sb1.pop_front();
      total++;
      if ({y1, g1, sq1} !== e || g1 !== g_tab[k] || y1 !== y_tab[k]) begin
        bad++;
        $display("FAIL lane_sweep[s=%0d]: got y=%b g=%b s_q=%0d want y=%b g=%b s_q=%0d",
                 k, y1, g1, sq1, y_tab[k], g_tab[k], e.sq);
      end
    end
  endtask

  task automatic test_random_sweep();
    exp1_t e;
    logic [3:0] rv;
    for (int n = 0; n < 5; n++) begin
      rv = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) begin
        cycle1(rv, 2'(k), 1'b1);
        e = sb1.pop_front();
        total++;
        if ({y1, g1, sq1} !== e) begin
          bad++;
          $display("FAIL random[i=%b s=%0d]: got y=%b g=%b s_q=%0d want y=%b g=%b s_q=%0d",
                   rv, k, y1, g1, sq1, e.y, e.g, e.sq);
        end
        total++;
        if ($countones(g1) > 1 || (|g1) !== y1) begin
          bad++;
          $display("FAIL random_invariant[i=%b s=%0d]: got g=%b y=%b want one-hot-or-zero g with |g == y",
                   rv, k, g1, y1);
        end
      end
    end
  endtask

  task automatic test_enable_hold();
    exp1_t e;
    cycle1(4'b0100, 2'd2, 1'b1);
    e = sb1.pop_front();
    total++;
    if ({y1, g1, sq1} !== e) begin
      bad++;
      $display("FAIL en_capture: got y=%b g=%b s_q=%0d want y=%b g=%b s_q=%0d",
               y1, g1, sq1, e.y, e.g, e.sq);
    end
    for (int k = 0; k < 3; k++) begin
      cycle1(4'b0001, 2'd0, 1'b0);
      e = sb1.pop_front();
      total++;
      if ({y1, g1, sq1} !== e || g1 !== 4'b0100 || sq1 !== 2'd2) begin
        bad++;
        $display("FAIL en_hold[%0d]: got y=%b g=%b s_q=%0d want y=1 g=0100 s_q=2", k, y1, g1, sq1);
      end
    end
    cycle1(4'b0001, 2'd0, 1'b1);
    e = sb1.pop_front();
    total++;
    if ({y1, g1, sq1} !== e || g1 !== 4'b0001) begin
      bad++;
      $display("FAIL en_resume: got y=%b g=%b s_q=%0d want y=1 g=0001 s_q=0", y1, g1, sq1);
    end
  endtask

  task automatic test_back_to_back();
    exp1_t e;
    cycle1(4'b1111, 2'd3, 1'b1);
    e = sb1.pop_front();
    total++;
    if ({y1, g1, sq1} !== e) begin
      bad++;
      $display("FAIL simul_first: got y=%b g=%b s_q=%0d want y=%b g=%b s_q=%0d",
               y1, g1, sq1, e.y, e.g, e.sq);
    end
    cycle1(4'b0110, 2'd1, 1'b1);
    e = sb1.pop_front();
    total++;
    if ({y1, g1, sq1} !== e || g1 !== 4'b0010 || y1 !== 1'b1) begin
      bad++;
      $display("FAIL simul_change: got y=%b g=%b s_q=%0d want y=1 g=0010 s_q=1", y1, g1, sq1);
    end
  endtask

  task automatic test_wide();
    expw_t e;
    logic [31:0] vec;
    vec = {8'hD4, 8'h00, 8'h5A, 8'hFF};
    // The wide instance has been idle since reset: it must still be zero
    cyclew(vec, 2'd1, 1'b0);
    e = sbw.pop_front();
    total++;
    if ({yw, gw, sqw} !== e) begin
      bad++;
      $display("FAIL wide_idle: got y=%h g=%h s_q=%0d want y=%h g=%h s_q=%0d",
               yw, gw, sqw, e.y, e.g, e.sq);
    end
    for (int k = 0; k < 4; k++) begin
      cyclew(vec, 2'((k + 1) % 4), 1'b1);
      e = sbw.pop_front();
      total++;
      if ({yw, gw, sqw} !== e) begin
        bad++;
        $display("FAIL wide[s=%0d]: got y=%h g=%h s_q=%0d want y=%h g=%h s_q=%0d",
                 (k + 1) % 4, yw, gw, sqw, e.y, e.g, e.sq);
      end
      if (k == 0) begin
        total++;
        if (yw !== 8'h5A || gw !== 32'h0000_5A00) begin
          bad++;
          $display("FAIL wide_lane1: got y=%h g=%h want y=5a g=00005a00", yw, gw);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    en1 = 1'b0;
    i1 = 4'b0000;
    s1 = 2'd0;
    enw = 1'b0;
    iw = 32'h0000_0000;
    sw = 2'd0;
    m1 = '0;
    mw = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_lane_sweep();
    test_random_sweep();
    test_enable_hold();
    test_back_to_back();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
